// File: rtl/lb_fifo_ctrl_if.sv
// Ready/valid stream, flush and line-buffer macro port bundle for lb_fifo_ctrl.
// The slave modport is the controller; the master modport is its surroundings.
interface lb_fifo_ctrl_if #(
  parameter int WIDTH  = 128,
  parameter int ADDR_W = 5
);
  logic              flush;
  logic              enq_valid;
  logic              enq_ready;
  logic [WIDTH-1:0]  enq_data;
  logic              deq_valid;
  logic              deq_ready;
  logic [WIDTH-1:0]  deq_data;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] mem_W0_addr;
  logic              mem_W0_en;
  logic [WIDTH-1:0]  mem_W0_data;
  logic [ADDR_W-1:0] mem_R0_addr;
  logic              mem_R0_en;
  logic [WIDTH-1:0]  mem_R0_data;

  modport slave (
    input  flush, enq_valid, enq_data, deq_ready, mem_R0_data,
    output enq_ready, deq_valid, deq_data, count,
           mem_W0_addr, mem_W0_en, mem_W0_data,
           mem_R0_addr, mem_R0_en
  );

  modport master (
    output flush, enq_valid, enq_data, deq_ready, mem_R0_data,
    input  enq_ready, deq_valid, deq_data, count,
           mem_W0_addr, mem_W0_en, mem_W0_data,
           mem_R0_addr, mem_R0_en
  );
endinterface

// File: rtl/lb_fifo_ctrl.sv
// Ready/valid FIFO built on a 1-cycle-latency line-buffer macro, with a
// 2-entry output buffer that hides the read latency for 1 word/cycle dequeue.
module lb_fifo_ctrl #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset_n,
  lb_fifo_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] MCNT_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    ST_RESET,
    ST_RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   mcnt;
  logic              inflight;
  logic [WIDTH-1:0]  ob [2];
  logic [1:0]        obcnt;

  logic              enq_rdy;
  logic              enq_fire;
  logic              deq_fire;
  logic              rd_issue;
  logic              ret;
  logic [2:0]        pend;
  logic [1:0]        slot;

  // Read issue looks at occupancy after this cycle's dequeue, so the buffer
  // can be refilled in the same cycle it is drained.
  always_comb begin
    enq_rdy  = (state == ST_RUN) && !bus.flush && (mcnt < MCNT_FULL);
    enq_fire = enq_rdy && bus.enq_valid;
    deq_fire = !bus.flush && (obcnt != 2'd0) && bus.deq_ready;
    pend     = {1'b0, obcnt} + {2'b00, inflight} - {2'b00, deq_fire};
    rd_issue = !bus.flush && (mcnt != '0) && (pend < 3'd2);
    ret      = inflight && !bus.flush;
    slot     = obcnt - {1'b0, deq_fire};
  end

  assign bus.enq_ready   = enq_rdy;
  assign bus.deq_valid   = (obcnt != 2'd0);
  assign bus.deq_data    = ob[0];
  assign bus.count       = mcnt + (ADDR_W+1)'(inflight) + (ADDR_W+1)'(obcnt);
  assign bus.mem_W0_en   = enq_fire;
  assign bus.mem_W0_addr = wptr;
  assign bus.mem_W0_data = bus.enq_data;
  assign bus.mem_R0_en   = rd_issue;
  assign bus.mem_R0_addr = rptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RESET;
      wptr     <= '0;
      rptr     <= '0;
      mcnt     <= '0;
      inflight <= 1'b0;
      obcnt    <= '0;
      ob[0]    <= '0;
      ob[1]    <= '0;
    end else begin
      state <= ST_RUN;
      if (bus.flush) begin
        wptr     <= '0;
        rptr     <= '0;
        mcnt     <= '0;
        inflight <= 1'b0;
        obcnt    <= '0;
      end else begin
        if (enq_fire) wptr <= wptr + 1'b1;
        if (rd_issue) rptr <= rptr + 1'b1;
        mcnt     <= mcnt + (ADDR_W+1)'(enq_fire) - (ADDR_W+1)'(rd_issue);
        inflight <= rd_issue;
        obcnt    <= obcnt + 2'(ret) - 2'(deq_fire);
        if (deq_fire) ob[0] <= ob[1];
        // A return lands in the slot left free after any shift; the later
        // assignment deliberately overrides the shift into ob[0].
        if (ret) begin
          if (slot == 2'd0) ob[0] <= bus.mem_R0_data;
          else              ob[1] <= bus.mem_R0_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_lb_fifo_ctrl.sv
// Directed self-checking bench for lb_fifo_ctrl with a behavioural macro beside it.
module tb_lb_fifo_ctrl;

  localparam int DEPTH  = 32;
  localparam int WIDTH  = 128;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  lb_fifo_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  lb_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: synchronous write, registered read one cycle after R0_en.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_W0_en) mem[bus.mem_W0_addr] <= bus.mem_W0_data;
    if (bus.mem_R0_en) bus.mem_R0_data <= mem[bus.mem_R0_addr];
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] pat_a5;
  int acc;
  int idx;
  int sent;
  int rcv;
  int gaps;
  int first_k;
  int seen;

  initial begin
    pat_a5 = {16{8'hA5}};
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.enq_valid = 1'b0;
    bus.enq_data = '0;
    bus.deq_ready = 1'b0;
    bus.mem_R0_data = '0;

    // Reset state
    @(negedge clk);
    check("rst_enq_ready", 128'(bus.enq_ready), 128'd0);
    check("rst_deq_valid", 128'(bus.deq_valid), 128'd0);
    check("rst_count", 128'(bus.count), 128'd0);
    check("rst_w0_en", 128'(bus.mem_W0_en), 128'd0);
    check("rst_r0_en", 128'(bus.mem_R0_en), 128'd0);
    check("rst_w0_addr", 128'(bus.mem_W0_addr), 128'd0);
    check("rst_r0_addr", 128'(bus.mem_R0_addr), 128'd0);
    check("rst_deq_data", bus.deq_data, '0);
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("post_rst_enq_ready", 128'(bus.enq_ready), 128'd1);
    check("post_rst_deq_valid", 128'(bus.deq_valid), 128'd0);
    step();

    // Empty-FIFO latency: enqueue at N, read at N+1, deq_valid at N+3
    bus.enq_valid = 1'b1;
    bus.enq_data = pat_a5;
    @(negedge clk);
    check("lat_w0_en", 128'(bus.mem_W0_en), 128'd1);
    check("lat_w0_addr", 128'(bus.mem_W0_addr), 128'd0);
    check("lat_w0_data", bus.mem_W0_data, pat_a5);
    step();
    bus.enq_valid = 1'b0;
    @(negedge clk);
    check("lat_r0_en_n1", 128'(bus.mem_R0_en), 128'd1);
    check("lat_r0_addr_n1", 128'(bus.mem_R0_addr), 128'd0);
    check("lat_count_n1", 128'(bus.count), 128'd1);
    step();
    @(negedge clk);
    check("lat_deq_valid_n2", 128'(bus.deq_valid), 128'd0);
    check("lat_count_n2", 128'(bus.count), 128'd1);
    check("lat_r0_en_n2", 128'(bus.mem_R0_en), 128'd0);
    step();
    @(negedge clk);
    check("lat_deq_valid_n3", 128'(bus.deq_valid), 128'd1);
    check("lat_deq_data_n3", bus.deq_data, pat_a5);
    check("lat_count_n3", 128'(bus.count), 128'd1);
    step();
    @(negedge clk);
    check("lat_stall_hold", bus.deq_data, pat_a5);
    step();
    bus.deq_ready = 1'b1;
    step();
    bus.deq_ready = 1'b0;
    @(negedge clk);
    check("lat_count_after_deq", 128'(bus.count), 128'd0);
    check("lat_deq_valid_after", 128'(bus.deq_valid), 128'd0);
    step();

    // Fill with the consumer stalled: capacity DEPTH+2
    acc = 0;
    for (int c = 0; c < 60; c++) begin
      bus.enq_valid = (acc < 40);
      bus.enq_data = WIDTH'(acc);
      @(negedge clk);
      if (bus.enq_valid && bus.enq_ready) acc++;
      step();
    end
    @(negedge clk);
    check("fill_accepted", 128'(acc), 128'd34);
    check("fill_count", 128'(bus.count), 128'd34);
    check("fill_enq_ready", 128'(bus.enq_ready), 128'd0);
    check("fill_head", bus.deq_data, 128'd0);
    step();
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 100 && idx < 34; c++) begin
      @(negedge clk);
      if (bus.deq_valid) begin
        check("drain_order", bus.deq_data, WIDTH'(idx));
        idx++;
      end
      step();
    end
    check("drain_total", 128'(idx), 128'd34);
    @(negedge clk);
    check("drain_count", 128'(bus.count), 128'd0);
    step();

    // Streaming 200 words across six pointer wraps
    sent = 0; rcv = 0; gaps = 0; first_k = -1;
    for (int k = 0; k < 400 && rcv < 200; k++) begin
      bus.enq_valid = (sent < 200);
      bus.enq_data = WIDTH'(32'h1000 + sent);
      @(negedge clk);
      if (bus.enq_valid && bus.enq_ready) sent++;
      if (bus.deq_valid) begin
        if (first_k < 0) first_k = k;
        check("stream_data", bus.deq_data, WIDTH'(32'h1000 + rcv));
        rcv++;
      end else if (rcv > 0) begin
        gaps++;
      end
      step();
    end
    bus.enq_valid = 1'b0;
    check("stream_rcv", 128'(rcv), 128'd200);
    check("stream_first", 128'(first_k), 128'd3);
    check("stream_gaps", 128'(gaps), 128'd0);
    @(negedge clk);
    check("stream_count", 128'(bus.count), 128'd0);
    step();

    // Flush with a read in flight
    bus.deq_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.enq_valid = 1'b1;
      bus.enq_data = WIDTH'(32'hF0 + c);
      step();
    end
    bus.enq_valid = 1'b0;
    step(); step(); step();
    @(negedge clk);
    check("fl_pre_count", 128'(bus.count), 128'd8);
    step();
    bus.deq_ready = 1'b1;
    @(negedge clk);
    check("fl_head", bus.deq_data, 128'hF0);
    check("fl_refill_read", 128'(bus.mem_R0_en), 128'd1);
    step();
    bus.flush = 1'b1;
    @(negedge clk);
    check("fl_count_during", 128'(bus.count), 128'd7);
    check("fl_enq_ready_during", 128'(bus.enq_ready), 128'd0);
    check("fl_deq_valid_during", 128'(bus.deq_valid), 128'd1);
    check("fl_r0_en_during", 128'(bus.mem_R0_en), 128'd0);
    step();
    bus.flush = 1'b0;
    bus.deq_ready = 1'b0;
    bus.enq_valid = 1'b1;
    bus.enq_data = 128'hBEEF;
    @(negedge clk);
    check("fl_count_after", 128'(bus.count), 128'd0);
    check("fl_deq_valid_after", 128'(bus.deq_valid), 128'd0);
    check("fl_wptr_cleared", 128'(bus.mem_W0_addr), 128'd0);
    check("fl_enq_ready_after", 128'(bus.enq_ready), 128'd1);
    step();
    bus.enq_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (bus.deq_valid) begin
        seen = 1;
        check("fl_next_word", bus.deq_data, 128'hBEEF);
        check("fl_next_count", 128'(bus.count), 128'd1);
      end
      step();
    end
    check("fl_next_seen", 128'(seen), 128'd1);

    // Asynchronous reset mid-operation
    bus.enq_valid = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 128'(bus.count), 128'd0);
    check("arst_deq_valid", 128'(bus.deq_valid), 128'd0);
    check("arst_enq_ready", 128'(bus.enq_ready), 128'd0);
    bus.enq_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
